// File: rtl/regfile_port_arbiter_if.sv
// Requester and Register-port bundle for regfile_port_arbiter.
// slave = arbiter side, master = requesters plus Register array.
interface regfile_port_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_rs1;
    logic [ADDR_WIDTH-1:0] rd_rs2;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rs1_data;
    logic [DATA_WIDTH-1:0] rsp_rs2_data;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_wen;
    logic                  reg_ren;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;

    modport slave (
        input  rd_valid, rd_rs1, rd_rs2, rsp_ready,
        input  wb_valid, wb_addr, wb_data, reg_rdata,
        output rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
        output wb_ready, reg_addr, reg_wen, reg_ren, reg_wdata
    );

    modport master (
        output rd_valid, rd_rs1, rd_rs2, rsp_ready,
        output wb_valid, wb_addr, wb_data, reg_rdata,
        input  rd_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
        input  wb_ready, reg_addr, reg_wen, reg_ren, reg_wdata
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Serializes decode reads and writeback writes onto one register port.
// Define REGARB_X0_ZERO_EN to hardwire address 0 to zero.
module regfile_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WR,
        RA,
        RB,
        RC,
        RSP
    } state_t;

    localparam logic GNT_RD = 1'b0;
    localparam logic GNT_WB = 1'b1;

    state_t                state;
    state_t                state_nx;
    logic                  last_grant;
    logic                  gnt_wb;
    logic                  gnt_rd;
    logic                  wr_en;
    logic                  rs1_kill;
    logic                  rs2_kill;
    logic [ADDR_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [ADDR_WIDTH-1:0] rs1_q;
    logic [ADDR_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] rs1_data_q;
    logic [DATA_WIDTH-1:0] rs2_data_q;

`ifdef REGARB_X0_ZERO_EN
    assign wr_en    = (wb_addr_q != '0);
    assign rs1_kill = (rs1_q == '0);
    assign rs2_kill = (rs2_q == '0);
`else
    assign wr_en    = 1'b1;
    assign rs1_kill = 1'b0;
    assign rs2_kill = 1'b0;
`endif

    // Ready is gated by rst so nothing handshakes while reset is held.
    always_comb begin
        gnt_wb = 1'b0;
        gnt_rd = 1'b0;
        if (state == IDLE && rst) begin
            if (bus.wb_valid && bus.rd_valid) begin
                gnt_wb = (last_grant == GNT_RD);
                gnt_rd = (last_grant == GNT_WB);
            end else begin
                gnt_wb = bus.wb_valid;
                gnt_rd = bus.rd_valid;
            end
        end
    end

    assign bus.wb_ready     = gnt_wb;
    assign bus.rd_ready     = gnt_rd;
    assign bus.rsp_valid    = (state == RSP);
    assign bus.rsp_rs1_data = rs1_data_q;
    assign bus.rsp_rs2_data = rs2_data_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (gnt_wb) begin
                    state_nx = WR;
                end else if (gnt_rd) begin
                    state_nx = RA;
                end
            end
            WR:  state_nx = IDLE;
            RA:  state_nx = RB;
            RB:  state_nx = RC;
            RC:  state_nx = RSP;
            RSP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.reg_wen   = 1'b0;
        bus.reg_ren   = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        unique case (state)
            WR: begin
                bus.reg_wen   = wr_en;
                bus.reg_addr  = wb_addr_q;
                bus.reg_wdata = wb_data_q;
            end
            RA: begin
                bus.reg_ren  = 1'b1;
                bus.reg_addr = rs1_q;
            end
            RB: begin
                bus.reg_ren  = 1'b1;
                bus.reg_addr = rs2_q;
            end
            default: begin
            end
        endcase
    end

    // rdata lags ren by one cycle: rs1 arrives in RB, rs2 in RC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_RD;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state <= state_nx;
            if (gnt_wb) begin
                wb_addr_q  <= bus.wb_addr;
                wb_data_q  <= bus.wb_data;
                last_grant <= GNT_WB;
            end
            if (gnt_rd) begin
                rs1_q      <= bus.rd_rs1;
                rs2_q      <= bus.rd_rs2;
                last_grant <= GNT_RD;
            end
            if (state == RB) begin
                rs1_data_q <= rs1_kill ? '0 : bus.reg_rdata;
            end
            if (state == RC) begin
                rs2_data_q <= rs2_kill ? '0 : bus.reg_rdata;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed cases, then random traffic
// checked every cycle against a transaction-level model.
module tb_regfile_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;

`ifdef REGARB_X0_ZERO_EN
    localparam bit X0 = 1'b1;
`else
    localparam bit X0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hA5C30000 ^ (32'(a) * 32'h00010001);
    endfunction

    // Register array: one port, synchronous read.
    logic [DW-1:0] env_mem [64];
    bit            env_wr  [64];
    always @(posedge clk) begin
        if (bus.reg_wen) begin
            env_mem[bus.reg_addr] <= bus.reg_wdata;
            env_wr[bus.reg_addr]  <= 1'b1;
        end
        if (bus.reg_ren) begin
            bus.reg_rdata <= env_wr[bus.reg_addr] ?
                             env_mem[bus.reg_addr] : init_val(bus.reg_addr);
        end
    end

    // Model: expected port ops per cycle, then a pending response.
    typedef struct packed {
        logic          wen;
        logic          ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    op_t           opq[$];
    logic [DW-1:0] m_mem [64];
    bit            m_wr  [64];
    bit            rsp_pend = 1'b0;
    bit            last_wr = 1'b0;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (X0 && a == 0) return '0;
        return m_wr[a] ? m_mem[a] : init_val(a);
    endfunction

    initial forever begin
        op_t op;
        bit  gw;
        bit  gr;
        @(negedge clk);
        if (!rst) begin
            chk("rst_wb_ready", bus.wb_ready, 0);
            chk("rst_rd_ready", bus.rd_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp1", bus.rsp_rs1_data, 0);
            chk("rst_rsp2", bus.rsp_rs2_data, 0);
            chk("rst_reg_wen", bus.reg_wen, 0);
            chk("rst_reg_ren", bus.reg_ren, 0);
            chk("rst_reg_addr", bus.reg_addr, 0);
            chk("rst_reg_wdata", bus.reg_wdata, 0);
            opq.delete();
            rsp_pend = 1'b0;
            last_wr  = 1'b0;
        end else begin
            chk("port_excl", bus.reg_wen & bus.reg_ren, 0);
            if (opq.size() != 0) begin
                op = opq.pop_front();
                chk("op_wen", bus.reg_wen, op.wen);
                chk("op_ren", bus.reg_ren, op.ren);
                chk("op_addr", bus.reg_addr, op.addr);
                chk("op_wdata", bus.reg_wdata, op.wdata);
                chk("busy_wb_ready", bus.wb_ready, 0);
                chk("busy_rd_ready", bus.rd_ready, 0);
                chk("busy_rsp_valid", bus.rsp_valid, 0);
                if (op.wen) begin
                    m_mem[op.addr] = op.wdata;
                    m_wr[op.addr]  = 1'b1;
                end
            end else if (rsp_pend) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_rs1", bus.rsp_rs1_data, e1);
                chk("rsp_rs2", bus.rsp_rs2_data, e2);
                chk("rsp_wb_ready", bus.wb_ready, 0);
                chk("rsp_rd_ready", bus.rd_ready, 0);
                chk("rsp_port", {bus.reg_wen, bus.reg_ren, bus.reg_addr}, 0);
                if (bus.rsp_ready) rsp_pend = 1'b0;
            end else begin
                gw = bus.wb_valid && (!bus.rd_valid || !last_wr);
                gr = bus.rd_valid && !gw;
                chk("idle_wb_ready", bus.wb_ready, gw);
                chk("idle_rd_ready", bus.rd_ready, gr);
                chk("idle_rsp_valid", bus.rsp_valid, 0);
                chk("idle_port", {bus.reg_wen, bus.reg_ren, bus.reg_addr}, 0);
                chk("idle_wdata", bus.reg_wdata, 0);
                if (gw) begin
                    opq.push_back(op_t'{!(X0 && bus.wb_addr == 0), 1'b0,
                                        bus.wb_addr, bus.wb_data});
                    last_wr = 1'b1;
                end else if (gr) begin
                    opq.push_back(op_t'{1'b0, 1'b1, bus.rd_rs1, DW'(0)});
                    opq.push_back(op_t'{1'b0, 1'b1, bus.rd_rs2, DW'(0)});
                    opq.push_back(op_t'{1'b0, 1'b0, AW'(0), DW'(0)});
                    e1 = model_rd(bus.rd_rs1);
                    e2 = model_rd(bus.rd_rs2);
                    rsp_pend = 1'b1;
                    last_wr  = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge of the WR cycle.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        @(posedge clk); #1;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        k = 0;
        @(negedge clk);
        while (!bus.wb_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("wr_grant", bus.wb_ready, 1);
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        @(negedge clk);
    endtask

    // lat counts negedges from the accept cycle to the first RSP cycle.
    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           output logic [DW-1:0] d1, output logic [DW-1:0] d2,
                           output int lat, output int rens);
        int k;
        @(posedge clk); #1;
        bus.rd_valid  = 1'b1;
        bus.rd_rs1    = a1;
        bus.rd_rs2    = a2;
        bus.rsp_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.rd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rd_grant", bus.rd_ready, 1);
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        lat  = 0;
        rens = 0;
        do begin
            @(negedge clk);
            lat++;
            rens += int'(bus.reg_ren);
        end while (!bus.rsp_valid && lat < 20);
        d1 = bus.rsp_rs1_data;
        d2 = bus.rsp_rs2_data;
    endtask

    initial begin
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        int            lat;
        int            rens;
        int            grants[$];

        bus.rd_valid  = 1'b0;
        bus.rd_rs1    = '0;
        bus.rd_rs2    = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        #1 rst = 1'b0;
        #1;
        chk("t0_rd_ready", bus.rd_ready, 0);
        chk("t0_rsp_valid", bus.rsp_valid, 0);
        chk("t0_rsp1", bus.rsp_rs1_data, 0);
        chk("t0_reg_wen", bus.reg_wen, 0);
        chk("t0_reg_ren", bus.reg_ren, 0);
        @(posedge clk); #1 rst = 1'b1;

        do_write(6'd5, 32'hDEADBEEF);
        chk("t1_wen", bus.reg_wen, 1);
        chk("t1_addr", bus.reg_addr, 5);
        chk("t1_wdata", bus.reg_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_idle_wen", bus.reg_wen, 0);

        do_read(6'd5, 6'd5, d1, d2, lat, rens);
        chk("t2_latency", lat, 4);
        chk("t2_ren_cycles", rens, 2);
        chk("t2_rs1", d1, 32'hDEADBEEF);
        chk("t2_rs2", d2, 32'hDEADBEEF);

        @(posedge clk); #1;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 6'd10;
        bus.wb_data  = 32'h0A0A0A0A;
        bus.rd_valid = 1'b1;
        bus.rd_rs1   = 6'd10;
        bus.rd_rs2   = 6'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wb_ready) grants.push_back(1);
            if (bus.rd_ready) grants.push_back(0);
        end
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        bus.rd_valid = 1'b0;
        chk("t3_grant_count", grants.size(), 4);
        foreach (grants[i]) chk("t3_alternate", grants[i], (i % 2 == 0));
        repeat (8) @(negedge clk);

        do_write(6'd7, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus.rd_valid  = 1'b1;
        bus.rd_rs1    = 6'd7;
        bus.rd_rs2    = 6'd5;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_rd_ready", bus.rd_ready, 1);
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 6'd9;
        bus.wb_data  = 32'h11112222;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chk("t4_latency", lat, 4);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            chk("t4_hold_valid", bus.rsp_valid, 1);
            chk("t4_hold_rs1", bus.rsp_rs1_data, 32'hCAFEF00D);
            chk("t4_hold_rs2", bus.rsp_rs2_data, 32'hDEADBEEF);
            chk("t4_wb_blocked", bus.wb_ready, 0);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_wb_ready", bus.wb_ready, 0);
        @(negedge clk);
        chk("t4_wb_after", bus.wb_ready, 1);
        @(posedge clk); #1 bus.wb_valid = 1'b0;

        @(posedge clk); #1;
        bus.rd_valid = 1'b1;
        bus.rd_rs1   = 6'd9;
        bus.rd_rs2   = 6'd7;
        @(negedge clk);
        chk("t5_rd_ready", bus.rd_ready, 1);
        @(posedge clk); #1 bus.rd_valid = 1'b0;
        @(posedge clk); #1;
        chk("t5_in_rb_ren", bus.reg_ren, 1);
        chk("t5_in_rb_addr", bus.reg_addr, 7);
        rst = 1'b0;
        #1;
        chk("t5_rst_ren", bus.reg_ren, 0);
        chk("t5_rst_addr", bus.reg_addr, 0);
        chk("t5_rst_rsp", bus.rsp_valid, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t5_no_rsp", bus.rsp_valid, 0);
        end
        @(posedge clk); #1 rst = 1'b1;
        do_read(6'd9, 6'd7, d1, d2, lat, rens);
        chk("t5_latency", lat, 4);
        chk("t5_rs1", d1, 32'h11112222);
        chk("t5_rs2", d2, 32'hCAFEF00D);

        do_write(6'd32, 32'h80000040);
        do_write(6'd0, 32'h00001234);
`ifdef REGARB_X0_ZERO_EN
        chk("t6_x0_wen", bus.reg_wen, 0);
`else
        chk("t6_r0_wen", bus.reg_wen, 1);
`endif
        do_read(6'd0, 6'd32, d1, d2, lat, rens);
`ifdef REGARB_X0_ZERO_EN
        chk("t6_x0_rs1", d1, 0);
`else
        chk("t6_r0_rs1", d1, 32'h00001234);
`endif
        chk("t6_pc_rs2", d2, 32'h80000040);
        chk("t6_latency", lat, 4);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst           = ($urandom_range(0, 399) != 0);
            bus.wb_valid  = ($urandom_range(0, 2) == 0);
            bus.wb_addr   = AW'($urandom_range(0, 32));
            bus.wb_data   = $urandom;
            bus.rd_valid  = 1'($urandom_range(0, 1));
            bus.rd_rs1    = AW'($urandom_range(0, 32));
            bus.rd_rs2    = ($urandom_range(0, 3) == 0) ?
                            bus.rd_rs1 : AW'($urandom_range(0, 32));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.rd_valid  = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_idle", opq.size() + int'(rsp_pend), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
